// File: rtl/ysyx_23060025_store_buf.sv
// Store buffer: queues LSU stores in a DEPTH-entry FIFO and replays them one at a time over AW/W/B channels.
// Latency: first AW/W valid one edge after the push edge into an empty idle buffer; one IDLE cycle between transactions.
// Backpressure: st_ready_o drops when the registered count is full; AW/W each hold until accepted. STORE_BUF_ERR_EN enables err_o.
module ysyx_23060025_store_buf #(
    parameter int DATA_LEN = 32,
    parameter int DEPTH    = 4
) (
    input  logic                clock,
    input  logic                rstn,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [DATA_LEN-1:0] st_addr_i,
    input  logic [DATA_LEN-1:0] st_data_i,
    input  logic [3:0]          st_mask_i,
    output logic                addr_w_valid_o,
    input  logic                addr_w_ready_i,
    output logic [DATA_LEN-1:0] addr_w_addr_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    output logic [DATA_LEN-1:0] w_data_o,
    output logic [3:0]          w_strb_o,
    input  logic                bkwd_valid_i,
    output logic                bkwd_ready_o,
    input  logic [1:0]          bkwd_resp_i,
    output logic                idle_o,
    output logic                err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [DATA_LEN-1:0] addr_mem_q [DEPTH];
    logic [DATA_LEN-1:0] data_mem_q [DEPTH];
    logic [3:0]          mask_mem_q [DEPTH];

    logic push, pop, aw_hs, w_hs;

    assign st_ready_o     = rstn & (count_q != CW'(DEPTH));
    assign push           = st_valid_i & st_ready_o;
    assign addr_w_valid_o = (state_q == SEND) & ~aw_done_q;
    assign w_valid_o      = (state_q == SEND) & ~w_done_q;
    assign bkwd_ready_o   = (state_q == WAIT_B);
    assign aw_hs          = addr_w_valid_o & addr_w_ready_i;
    assign w_hs           = w_valid_o & w_ready_i;
    assign pop            = bkwd_valid_i & bkwd_ready_o;
    assign idle_o         = (count_q == '0) & (state_q == IDLE);

    // Head entry stays put until the B handshake, so payloads are stable while valid.
    assign addr_w_addr_o = addr_mem_q[rd_ptr_q];
    assign w_data_o      = data_mem_q[rd_ptr_q];
    assign w_strb_o      = mask_mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = SEND;
            end
            SEND: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = WAIT_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WAIT_B: begin
                if (pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= st_addr_i;
            data_mem_q[wr_ptr_q] <= st_data_i;
            mask_mem_q[wr_ptr_q] <= st_mask_i;
        end
    end

`ifdef STORE_BUF_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (pop & (bkwd_resp_i != 2'b00));
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`else
    logic resp_unused;
    assign resp_unused = ^bkwd_resp_i;
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060025_store_buf.sv
// Directed bench for the store buffer: a cycle table for single and split-handshake transactions,
// then hand-written sequences for full FIFO, push/pop overlap with wrap, error flag and mid-transaction reset.
module tb_ysyx_23060025_store_buf;
    logic        clock = 1'b0;
    logic        rstn;
    logic        st_v, st_rdy, aw_v, aw_r, w_v, w_r, bk_v, bk_r, idle, err;
    logic [31:0] st_addr, st_data, aw_addr, w_data;
    logic [3:0]  st_mask, w_strb;
    logic [1:0]  resp;

    always #5 clock = ~clock;

    ysyx_23060025_store_buf #(.DATA_LEN(32), .DEPTH(4)) dut (
        .clock(clock), .rstn(rstn),
        .st_valid_i(st_v), .st_ready_o(st_rdy),
        .st_addr_i(st_addr), .st_data_i(st_data), .st_mask_i(st_mask),
        .addr_w_valid_o(aw_v), .addr_w_ready_i(aw_r), .addr_w_addr_o(aw_addr),
        .w_valid_o(w_v), .w_ready_i(w_r), .w_data_o(w_data), .w_strb_o(w_strb),
        .bkwd_valid_i(bk_v), .bkwd_ready_o(bk_r), .bkwd_resp_i(resp),
        .idle_o(idle), .err_o(err)
    );

`ifdef STORE_BUF_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_b    = 0;
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];

    always @(posedge clock) begin
        if (aw_v && aw_r) aw_log.push_back(aw_addr);
        if (w_v && w_r)   w_log.push_back(w_data);
        if (bk_v && bk_r) n_b++;
    end

    typedef struct {
        logic        sv;
        logic [31:0] addr, data;
        logic [3:0]  mask;
        logic        awr, wr, bv;
        logic [1:0]  rsp;
        logic        e_rdy, e_awv, e_wv, e_br, e_idle;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_strb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: got no event expected event within cycle budget", nm);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        st_v = 0; st_addr = '0; st_data = '0; st_mask = '0;
        aw_r = 0; w_r = 0; bk_v = 0; resp = 2'b00;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rstn = 1'b0;
        repeat (2) cyc();
        chk("rst_st_ready", st_rdy, 0);
        chk("rst_aw_valid", aw_v, 0);
        chk("rst_w_valid", w_v, 0);
        chk("rst_b_ready", bk_r, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        rstn = 1'b1;
        cyc();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int k;
        st_v = 1; st_addr = a; st_data = d; st_mask = m;
        for (k = 0; k < 50; k++) begin
            @(negedge clock);
            if (st_rdy) break;
            cyc();
        end
        if (k == 50) timeout("push_accept");
        cyc();
        st_v = 0;
    endtask

    task automatic drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            if (idle) break;
            cyc();
        end
        if (k == budget) timeout("drain_idle");
        cyc();
    endtask

    localparam logic [31:0] A1 = 32'hA000_03F8, D1 = 32'h0000_0041;
    localparam logic [31:0] A2 = 32'h1000_0010, D2 = 32'hCAFE_F00D;

    vec_t vecs[15];
    int   base, b_base;

    initial begin
        //        sv    addr   data   mask   awr   wr    bv    rsp    rdy   awv   wv    br    idle  e_addr e_data e_strb
        vecs[0]  = '{1'b1, A1,   D1,   4'h1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0};
        vecs[1]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[2]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, A1,    D1,    4'h1};
        vecs[3]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[4]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0};
        vecs[5]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0};
        vecs[6]  = '{1'b1, A2,   D2,   4'hF, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0};
        vecs[7]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[8]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, A2,    D2,    4'hF};
        vecs[9]  = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A2,    32'h0, 4'h0};
        vecs[10] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A2,    32'h0, 4'h0};
        vecs[11] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A2,    32'h0, 4'h0};
        vecs[12] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[13] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[14] = '{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0};

        rstn = 1'b0;
        quiet_inputs();
        do_reset();

        // Single transaction, then W accepted three cycles ahead of AW.
        b_base = n_b;
        for (int i = 0; i < 15; i++) begin
            st_v = vecs[i].sv; st_addr = vecs[i].addr; st_data = vecs[i].data; st_mask = vecs[i].mask;
            aw_r = vecs[i].awr; w_r = vecs[i].wr; bk_v = vecs[i].bv; resp = vecs[i].rsp;
            @(negedge clock);
            chk($sformatf("vec%0d_st_ready", i), st_rdy, vecs[i].e_rdy);
            chk($sformatf("vec%0d_aw_valid", i), aw_v, vecs[i].e_awv);
            chk($sformatf("vec%0d_w_valid", i), w_v, vecs[i].e_wv);
            chk($sformatf("vec%0d_b_ready", i), bk_r, vecs[i].e_br);
            chk($sformatf("vec%0d_idle", i), idle, vecs[i].e_idle);
            if (vecs[i].e_awv) chk($sformatf("vec%0d_aw_addr", i), aw_addr, vecs[i].e_addr);
            if (vecs[i].e_wv) begin
                chk($sformatf("vec%0d_w_data", i), w_data, vecs[i].e_data);
                chk($sformatf("vec%0d_w_strb", i), w_strb, 32'(vecs[i].e_strb));
            end
            cyc();
        end
        chk("table_b_count", 32'(n_b - b_base), 2);

        // Fill with downstream stalled; fifth push waits for the first pop.
        do_reset();
        base = aw_log.size();
        bk_v = 1;
        st_v = 1; st_mask = 4'h3;
        for (int i = 0; i < 4; i++) begin
            st_addr = 32'h8000_0000 + 32'(i) * 4;
            st_data = 32'h1111_0000 + 32'(i);
            @(negedge clock);
            chk("fill_st_ready", st_rdy, 1);
            cyc();
        end
        st_addr = 32'h8000_0010; st_data = 32'h1111_0004;
        @(negedge clock);
        chk("full_st_ready", st_rdy, 0);
        chk("full_aw_stalled", aw_v, 1);
        cyc();
        @(negedge clock);
        chk("full_st_ready2", st_rdy, 0);
        cyc();
        aw_r = 1; w_r = 1;
        @(negedge clock);
        chk("full_st_ready3", st_rdy, 0);
        cyc();
        @(negedge clock);
        chk("full_b_ready", bk_r, 1);
        chk("pop_cycle_st_ready", st_rdy, 0);
        cyc();
        @(negedge clock);
        chk("after_pop_st_ready", st_rdy, 1);
        cyc();
        st_v = 0;
        drain(200);
        chk("fill_aw_count", 32'(aw_log.size() - base), 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < aw_log.size()) chk("fill_aw_order", aw_log[base + i], 32'h8000_0000 + 32'(i) * 4);
            if (base + i < w_log.size())  chk("fill_w_order", w_log[base + i], 32'h1111_0000 + 32'(i));
        end

        // Push and pop in the same cycle at count 2, then wrap over 8 entries.
        do_reset();
        base = aw_log.size();
        aw_r = 1; w_r = 1; st_mask = 4'hF;
        st_v = 1; st_addr = 32'h2000_0000; st_data = 32'hB0B0_0000; cyc();
        st_addr = 32'h2000_0010; st_data = 32'hB0B0_0001; cyc();
        st_v = 0;
        @(negedge clock);
        chk("ovl_send", aw_v, 1);
        cyc();
        st_v = 1; st_addr = 32'h2000_0020; st_data = 32'hB0B0_0002; bk_v = 1;
        @(negedge clock);
        chk("ovl_st_ready", st_rdy, 1);
        chk("ovl_b_ready", bk_r, 1);
        cyc();
        bk_v = 0; aw_r = 0; w_r = 0;
        st_addr = 32'h2000_0030; st_data = 32'hB0B0_0003;
        @(negedge clock);
        chk("ovl_cnt_rdy3", st_rdy, 1);
        cyc();
        st_addr = 32'h2000_0040; st_data = 32'hB0B0_0004;
        @(negedge clock);
        chk("ovl_cnt_rdy4", st_rdy, 1);
        cyc();
        st_v = 0;
        @(negedge clock);
        chk("ovl_full", st_rdy, 0);
        cyc();
        aw_r = 1; w_r = 1; bk_v = 1;
        for (int i = 5; i < 8; i++) push(32'h2000_0000 + 32'(i) * 16, 32'hB0B0_0000 + 32'(i), 4'hF);
        drain(300);
        chk("wrap_aw_count", 32'(aw_log.size() - base), 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < aw_log.size()) chk("wrap_aw_order", aw_log[base + i], 32'h2000_0000 + 32'(i) * 16);
            if (base + i < w_log.size())  chk("wrap_w_order", w_log[base + i], 32'hB0B0_0000 + 32'(i));
        end

        // Error response sets the sticky flag only when the error logic is built in.
        do_reset();
        base = aw_log.size();
        aw_r = 1; w_r = 1; bk_v = 1; resp = 2'b10;
        push(32'h3000_0000, 32'h0000_00EE, 4'h1);
        drain(50);
        chk("err_set", err, EXP_ERR);
        chk("err_entry_issued", 32'(aw_log.size() - base), 1);
        resp = 2'b00;
        push(32'h3000_0004, 32'h0000_00EF, 4'h2);
        drain(50);
        chk("err_sticky", err, EXP_ERR);
        chk("err_second_issued", 32'(aw_log.size() - base), 2);

        // Reset pulled low while waiting for B with three entries buffered.
        do_reset();
        aw_r = 1; w_r = 1;
        st_v = 1; st_addr = 32'h4000_0000; st_data = 32'h1; cyc();
        st_addr = 32'h4000_0004; st_data = 32'h2; cyc();
        st_addr = 32'h4000_0008; st_data = 32'h3;
        @(negedge clock);
        chk("rst_mid_push3", st_rdy, 1);
        cyc();
        st_v = 0;
        @(negedge clock);
        chk("rst_mid_waitb", bk_r, 1);
        #1 rstn = 1'b0;
        #1;
        chk("amid_st_ready", st_rdy, 0);
        chk("amid_aw_valid", aw_v, 0);
        chk("amid_w_valid", w_v, 0);
        chk("amid_b_ready", bk_r, 0);
        chk("amid_idle", idle, 1);
        chk("amid_err", err, 0);
        base = aw_log.size();
        bk_v = 1;
        repeat (3) cyc();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("post_rst_idle", idle, 1);
            chk("post_rst_aw_valid", aw_v, 0);
            cyc();
        end
        chk("post_rst_no_aw", 32'(aw_log.size() - base), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
